branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  In-order queue of in-flight conditional-branch predictions, between fetch (allocates at predict time) and
//  execute (resolves in program order). Each resolution pops the oldest entry and emits one registered training
//  update (wPCindex/taken) to the branch predictor, plus a mispredict pulse carrying the repaired global history.
//  A mispredict flushes all younger entries.
// PARAMETERS
//  DEPTH   8  entries in flight; power of two, >=2
//  IDX_W   4  width of predictor PC index
//  GHR_W   4  width of global-history snapshot stored per entry
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          synchronous reset, active-high
//  alloc_valid    in   1          fetch presents a predicted branch
//  alloc_ready    out  1          = !full; alloc fires when alloc_valid && alloc_ready
//  alloc_pc_index in   IDX_W      PC index used for the prediction
//  alloc_pred     in   1          predicted direction (1 = taken)
//  alloc_ghr      in   GHR_W      global history used for the prediction
//  resolve_valid  in   1          execute resolves the oldest branch
//  resolve_taken  in   1          actual direction
//  upd_valid      out  1          registered: training update valid (1-cycle pulse)
//  upd_pc_index   out  IDX_W      registered: index to train (predictor wPCindex)
//  upd_taken      out  1          registered: actual outcome (predictor taken)
//  mispredict     out  1          registered: pulse, resolved direction != stored prediction
//  recover_ghr    out  GHR_W      registered: {stored_ghr[GHR_W-2:0], resolve_taken}
//  count          out  clog2(DEPTH+1)  occupied entries
//  empty          out  1          count == 0
//  full           out  1          count == DEPTH
//  underflow_err  out  1          sticky: resolve_valid seen while empty; cleared only by rst
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, upd_valid=0, upd_pc_index=0, upd_taken=0,
//    mispredict=0, recover_ghr=0, underflow_err=0; empty=1, full=0, alloc_ready=1. Entry contents undefined.
//    rst mid-operation discards all entries; any alloc/resolve in that cycle is ignored.
//  - Storage: circular buffer, pointers wrap DEPTH-1 -> 0; count tracked explicitly (no pointer-compare ambiguity).
//  - Alloc fire: write {pc_index, pred, ghr} at wr_ptr, wr_ptr++, count++.
//  - Resolve fire (resolve_valid && !empty): read head at rd_ptr, rd_ptr++, count--.
//    Next cycle: upd_valid=1, upd_pc_index=head.pc_index, upd_taken=resolve_taken,
//    mispredict=(head.pred != resolve_taken), recover_ghr as above. Latency = 1 cycle.
//  - No resolve fire: upd_valid=0, mispredict=0; upd_pc_index/upd_taken/recover_ghr hold last value.
//  - Resolve while empty: no pop, no update, underflow_err set; no bypass of a same-cycle alloc.
//  - Mispredicting resolve: at that edge wr_ptr=rd_ptr=0, count=0 (all younger entries flushed);
//    a same-cycle alloc is discarded. Update/mispredict outputs still issued next cycle.
//  - Simultaneous alloc+correct resolve, not full: both fire, count unchanged.
//  - Full: alloc_ready=0 even if resolve fires same cycle (no pass-through); slot reusable next cycle.
//  - alloc_ready, empty, full, count derive from registered state only (no combinational input->output path).
//  - Back-to-back resolves produce one upd_valid pulse per cycle; no internal throttling.
// TESTING
//  1. rst, alloc idx=3 pred=1 ghr=4'b0101; resolve taken=1 -> next cycle upd_valid=1, upd_pc_index=3,
//     upd_taken=1, mispredict=0, recover_ghr=4'b1011; count back to 0.
//  2. Alloc 8 entries -> full=1, alloc_ready=0, count=8; 9th alloc dropped; resolve 8 correct in order ->
//     upd_pc_index sequence matches alloc order, pointers wrap, empty=1.
//  3. Alloc idx 1,2,3 (pred 1,1,1); resolve first with taken=0 -> mispredict=1, upd_pc_index=1, count=0;
//     following resolve_valid sets underflow_err=1, upd_valid stays 0.
//  4. With count=8, assert alloc_valid and correct resolve same cycle -> alloc rejected, count=7;
//     with count=4 same stimulus -> count stays 4, both take effect.
//  5. Mispredicting resolve with simultaneous alloc -> alloc discarded, count=0 next cycle.
//  6. rst asserted with count=5 and resolve_valid high -> all outputs at reset values next cycle, no upd_valid.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order queue of predicted conditional branches. Fetch allocates an entry
// at predict time; execute resolves entries oldest-first. Each resolution
// produces a registered training update for the predictor and, when the
// stored prediction was wrong, a mispredict pulse with the repaired history.
// A mispredict flushes every younger entry still in the queue.
module branch_resolve_queue #(
   parameter int DEPTH = 8,
   parameter int IDX_W = 4,
   parameter int GHR_W = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           alloc_valid,
   output logic                           alloc_ready,
   input  logic [IDX_W-1:0]               alloc_pc_index,
   input  logic                           alloc_pred,
   input  logic [GHR_W-1:0]               alloc_ghr,
   input  logic                           resolve_valid,
   input  logic                           resolve_taken,
   output logic                           upd_valid,
   output logic [IDX_W-1:0]               upd_pc_index,
   output logic                           upd_taken,
   output logic                           mispredict,
   output logic [GHR_W-1:0]               recover_ghr,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty,
   output logic                           full,
   output logic                           underflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Entry storage; contents are don't-care until written, so no reset.
   logic [IDX_W-1:0] mem_idx_q  [DEPTH];
   logic             mem_pred_q [DEPTH];
   logic [GHR_W-1:0] mem_ghr_q  [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             upd_valid_q, upd_valid_d;
   logic [IDX_W-1:0] upd_pc_index_q, upd_pc_index_d;
   logic             upd_taken_q, upd_taken_d;
   logic             mispredict_q, mispredict_d;
   logic [GHR_W-1:0] recover_ghr_q, recover_ghr_d;
   logic             underflow_q, underflow_d;

   logic             empty_s;
   logic             full_s;
   logic             alloc_fire_s;
   logic             resolve_fire_s;
   logic             mispred_s;
   logic [IDX_W-1:0] head_idx_s;
   logic             head_pred_s;
   logic [GHR_W-1:0] head_ghr_s;

   // Status flags come from registered occupancy only, so there is no
   // combinational path from any input to these outputs.
   assign empty_s       = (count_q == CNT_W'(0));
   assign full_s        = (count_q == CNT_W'(DEPTH));
   assign alloc_ready   = !full_s;
   assign empty         = empty_s;
   assign full          = full_s;
   assign count         = count_q;
   assign upd_valid     = upd_valid_q;
   assign upd_pc_index  = upd_pc_index_q;
   assign upd_taken     = upd_taken_q;
   assign mispredict    = mispredict_q;
   assign recover_ghr   = recover_ghr_q;
   assign underflow_err = underflow_q;

   // Handshake qualification and head-of-queue read.
   always_comb begin
      alloc_fire_s   = alloc_valid && !full_s;
      resolve_fire_s = resolve_valid && !empty_s;
      head_idx_s     = mem_idx_q[rd_ptr_q];
      head_pred_s    = mem_pred_q[rd_ptr_q];
      head_ghr_s     = mem_ghr_q[rd_ptr_q];
      mispred_s      = resolve_fire_s && (head_pred_s != resolve_taken);
   end

   // Pointer and occupancy update; a mispredict empties the queue outright
   // and drops any allocation arriving in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (mispred_s) begin
         wr_ptr_d = PTR_W'(0);
         rd_ptr_d = PTR_W'(0);
         count_d  = CNT_W'(0);
      end else begin
         if (alloc_fire_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (resolve_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CNT_W'(alloc_fire_s) - CNT_W'(resolve_fire_s);
      end
   end

   // Training/recovery outputs: pulses follow the resolve, data holds when idle.
   always_comb begin
      upd_valid_d    = resolve_fire_s;
      mispredict_d   = mispred_s;
      upd_pc_index_d = upd_pc_index_q;
      upd_taken_d    = upd_taken_q;
      recover_ghr_d  = recover_ghr_q;
      if (resolve_fire_s) begin
         upd_pc_index_d = head_idx_s;
         upd_taken_d    = resolve_taken;
         recover_ghr_d  = {head_ghr_s[GHR_W-2:0], resolve_taken};
      end else begin
         upd_pc_index_d = upd_pc_index_q;
         upd_taken_d    = upd_taken_q;
         recover_ghr_d  = recover_ghr_q;
      end
      underflow_d = underflow_q | (resolve_valid & empty_s);
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q       <= PTR_W'(0);
         rd_ptr_q       <= PTR_W'(0);
         count_q        <= CNT_W'(0);
         upd_valid_q    <= 1'b0;
         upd_pc_index_q <= IDX_W'(0);
         upd_taken_q    <= 1'b0;
         mispredict_q   <= 1'b0;
         recover_ghr_q  <= GHR_W'(0);
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         upd_valid_q    <= upd_valid_d;
         upd_pc_index_q <= upd_pc_index_d;
         upd_taken_q    <= upd_taken_d;
         mispredict_q   <= mispredict_d;
         recover_ghr_q  <= recover_ghr_d;
         underflow_q    <= underflow_d;
      end
   end

   // Entry write at the tail; skipped when a mispredict flushes this cycle.
   always_ff @(posedge clk) begin
      if (!rst && alloc_fire_s && !mispred_s) begin
         mem_idx_q[wr_ptr_q]  <= alloc_pc_index;
         mem_pred_q[wr_ptr_q] <= alloc_pred;
         mem_ghr_q[wr_ptr_q]  <= alloc_ghr;
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic compared
// against a queue-based reference model.
module tb_branch_resolve_queue;

   localparam int DEPTH = 8;

   logic       clk;
   logic       rst;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [3:0] alloc_pc_index;
   logic       alloc_pred;
   logic [3:0] alloc_ghr;
   logic       resolve_valid;
   logic       resolve_taken;
   logic       upd_valid;
   logic [3:0] upd_pc_index;
   logic       upd_taken;
   logic       mispredict;
   logic [3:0] recover_ghr;
   logic [3:0] count;
   logic       empty;
   logic       full;
   logic       underflow_err;

   int checks = 0;
   int errors = 0;

   branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(4), .GHR_W(4)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_pc_index(alloc_pc_index), .alloc_pred(alloc_pred), .alloc_ghr(alloc_ghr),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .upd_valid(upd_valid), .upd_pc_index(upd_pc_index), .upd_taken(upd_taken),
      .mispredict(mispredict), .recover_ghr(recover_ghr),
      .count(count), .empty(empty), .full(full), .underflow_err(underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain queue of in-flight branches.
   typedef struct {
      logic [3:0] idx;
      logic       pred;
      logic [3:0] ghr;
   } ent_t;

   ent_t       mq[$];
   logic       m_uv;
   logic [3:0] m_idx;
   logic       m_tk;
   logic       m_mis;
   logic [3:0] m_ghr;
   logic       m_uf;

   task automatic model_step(input logic r, input logic av, input logic [3:0] idx,
                             input logic pr, input logic [3:0] g,
                             input logic rv, input logic tk);
      ent_t h;
      ent_t n;
      bit   afire;
      bit   was_full;
      bit   was_empty;
      if (r) begin
         mq.delete();
         m_uv = 1'b0; m_idx = 4'd0; m_tk = 1'b0; m_mis = 1'b0; m_ghr = 4'd0; m_uf = 1'b0;
      end else begin
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         afire     = av && !was_full;
         m_uv  = 1'b0;
         m_mis = 1'b0;
         if (rv && was_empty) m_uf = 1'b1;
         if (rv && !was_empty) begin
            h = mq.pop_front();
            m_uv  = 1'b1;
            m_idx = h.idx;
            m_tk  = tk;
            m_mis = (h.pred != tk);
            m_ghr = {h.ghr[2:0], tk};
            if (m_mis) begin
               mq.delete();
               afire = 1'b0;
            end
         end
         if (afire) begin
            n.idx = idx; n.pred = pr; n.ghr = g;
            mq.push_back(n);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("upd_valid",    32'(upd_valid),     32'(m_uv));
      chk("upd_pc_index", 32'(upd_pc_index),  32'(m_idx));
      chk("upd_taken",    32'(upd_taken),     32'(m_tk));
      chk("mispredict",   32'(mispredict),    32'(m_mis));
      chk("recover_ghr",  32'(recover_ghr),   32'(m_ghr));
      chk("count",        32'(count),         32'(mq.size()));
      chk("empty",        32'(empty),         32'(mq.size() == 0));
      chk("full",         32'(full),          32'(mq.size() == DEPTH));
      chk("alloc_ready",  32'(alloc_ready),   32'(mq.size() != DEPTH));
      chk("underflow",    32'(underflow_err), 32'(m_uf));
   endtask

   // One cycle: drive, clock, advance model, compare just after the edge.
   task automatic step(input logic r, input logic av, input logic [3:0] idx,
                       input logic pr, input logic [3:0] g,
                       input logic rv, input logic tk);
      rst = r; alloc_valid = av; alloc_pc_index = idx; alloc_pred = pr; alloc_ghr = g;
      resolve_valid = rv; resolve_taken = tk;
      @(posedge clk);
      model_step(r, av, idx, pr, g, rv, tk);
      #1;
      chk_model();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   // Directed vectors with hand-derived expectations.
   typedef struct {
      logic       r, av;
      logic [3:0] idx;
      logic       pr;
      logic [3:0] g;
      logic       rv, tk;
      logic       e_uv;
      logic [3:0] e_idx;
      logic       e_tk, e_mis;
      logic [3:0] e_ghr;
      logic [3:0] e_cnt;
      logic       e_uf;
   } vec_t;

   function automatic vec_t mk(logic r, logic av, logic [3:0] idx, logic pr, logic [3:0] g,
                               logic rv, logic tk, logic e_uv, logic [3:0] e_idx, logic e_tk,
                               logic e_mis, logic [3:0] e_ghr, logic [3:0] e_cnt, logic e_uf);
      vec_t v;
      v.r = r; v.av = av; v.idx = idx; v.pr = pr; v.g = g; v.rv = rv; v.tk = tk;
      v.e_uv = e_uv; v.e_idx = e_idx; v.e_tk = e_tk; v.e_mis = e_mis;
      v.e_ghr = e_ghr; v.e_cnt = e_cnt; v.e_uf = e_uf;
      return v;
   endfunction

   vec_t vt[13];

   initial begin
      //         r     av    idx   pr    ghr      rv    tk    uv    uidx  utk   mis   rghr     cnt   uf
      vt[0]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);
      vt[1]  = mk(1'b0, 1'b1, 4'd3, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd1, 1'b0);
      vt[2]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'b1011, 4'd0, 1'b0);
      vt[3]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'b1011, 4'd0, 1'b0);
      vt[4]  = mk(1'b0, 1'b1, 4'd1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'b1011, 4'd1, 1'b0);
      vt[5]  = mk(1'b0, 1'b1, 4'd2, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'b1011, 4'd2, 1'b0);
      vt[6]  = mk(1'b0, 1'b1, 4'd3, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 4'b1011, 4'd3, 1'b0);
      vt[7]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 4'b0010, 4'd0, 1'b0);
      vt[8]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'b0010, 4'd0, 1'b1);
      vt[9]  = mk(1'b0, 1'b1, 4'd5, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 4'b0010, 4'd1, 1'b1);
      vt[10] = mk(1'b0, 1'b1, 4'd6, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'b0001, 4'd0, 1'b1);
      vt[11] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 4'b0001, 4'd0, 1'b1);
      vt[12] = mk(1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'd0, 1'b0);

      rst = 1'b1; alloc_valid = 1'b0; alloc_pc_index = 4'd0; alloc_pred = 1'b0;
      alloc_ghr = 4'd0; resolve_valid = 1'b0; resolve_taken = 1'b0;
      m_uv = 1'b0; m_idx = 4'd0; m_tk = 1'b0; m_mis = 1'b0; m_ghr = 4'd0; m_uf = 1'b0;

      // Directed table: single resolve, flush on mispredict, underflow, flush with alloc.
      for (int i = 0; i < 13; i++) begin
         step(vt[i].r, vt[i].av, vt[i].idx, vt[i].pr, vt[i].g, vt[i].rv, vt[i].tk);
         chk("tbl_upd_valid",  32'(upd_valid),     32'(vt[i].e_uv));
         chk("tbl_upd_idx",    32'(upd_pc_index),  32'(vt[i].e_idx));
         chk("tbl_upd_taken",  32'(upd_taken),     32'(vt[i].e_tk));
         chk("tbl_mispredict", 32'(mispredict),    32'(vt[i].e_mis));
         chk("tbl_recover",    32'(recover_ghr),   32'(vt[i].e_ghr));
         chk("tbl_count",      32'(count),         32'(vt[i].e_cnt));
         chk("tbl_underflow",  32'(underflow_err), 32'(vt[i].e_uf));
      end

      // Fill to full with offset pointers, drop 9th alloc, drain in order.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      end
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 1'b1, 4'(i + 1), 1'b1, 4'(i), 1'b0, 1'b0);
      chk("full_flag",  32'(full),        32'd1);
      chk("full_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count),       32'd8);
      step(1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("ninth_drop", 32'(count),       32'd8);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
         chk("drain_order", 32'(upd_pc_index), 32'(i + 1));
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Full plus simultaneous resolve: alloc rejected; at count 4 both fire.
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 4'd12, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("full_simul_cnt", 32'(count), 32'd7);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("count_four", 32'(count), 32'd4);
      step(1'b0, 1'b1, 4'd13, 1'b0, 4'd0, 1'b1, 1'b0);
      chk("simul_cnt4", 32'(count), 32'd4);
      chk("simul_upd",  32'(upd_valid), 32'd1);

      // Reset while occupied and resolving.
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 4'(i + 2), 1'b1, 4'(i + 7), 1'b0, 1'b0);
      chk("pre_rst_cnt", 32'(count), 32'd5);
      step(1'b1, 1'b1, 4'd14, 1'b1, 4'd3, 1'b1, 1'b0);
      chk("rst_upd",   32'(upd_valid),   32'd0);
      chk("rst_count", 32'(count),       32'd0);
      chk("rst_ready", 32'(alloc_ready), 32'd1);
      chk("rst_empty", 32'(empty),       32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 99) < 60),
              4'($urandom), 1'($urandom),
              4'($urandom),
              1'($urandom_range(0, 99) < 45),
              1'($urandom_range(0, 99) < 70));
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
